// File: rtl/freq_meas_ctrl.sv
// rtl/freq_meas_ctrl.sv - equal-precision frequency meter sequencer with double-buffered byte readout
module freq_meas_ctrl #(
    parameter int GATE_CYCLES    = 50_000_000,
    parameter int TIMEOUT_CYCLES = 100_000_000,
    parameter int CNT_W          = 32
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       start,
    input  logic       auto_mode,
    input  logic       fx,
    input  logic       ack,
    input  logic [2:0] sel,
    output logic [7:0] data_out,
    output logic       irq,
    output logic       busy,
    output logic       timeout
);
    localparam int GATE_W = $clog2(GATE_CYCLES + 1);
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BYTES  = CNT_W / 8;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_GATE, S_CLOSE, S_DONE} state_t;

    state_t            state;
    logic              fx_s1, fx_s2, fx_prev;
    logic              fx_rise;
    logic [CNT_W-1:0]  fx_cnt, base_cnt;
    logic [CNT_W-1:0]  fx_res, base_res;
    logic [GATE_W-1:0] gate_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  sel_word;
    logic [7:0]        sel_byte;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign fx_rise  = fx_s2 & ~fx_prev;
    assign sel_word = sel[2] ? base_res : fx_res;
    assign sel_byte = 8'(sel_word >> {sel[1:0], 3'b000});

    always_ff @(posedge sysclk) begin
        if (reset) begin
            fx_s1   <= 1'b0;
            fx_s2   <= 1'b0;
            fx_prev <= 1'b0;
        end else begin
            fx_s1   <= fx;
            fx_s2   <= fx_s1;
            fx_prev <= fx_s2;
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            data_out <= 8'h00;
        end else if (32'(sel[1:0]) < BYTES) begin
            data_out <= sel_byte;
        end else begin
            data_out <= 8'h00;
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state    <= S_IDLE;
            fx_cnt   <= '0;
            base_cnt <= '0;
            gate_cnt <= '0;
            wait_cnt <= '0;
            fx_res   <= '0;
            base_res <= '0;
            irq      <= 1'b0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_ARM;
                        busy     <= 1'b1;
                        wait_cnt <= '0;
                    end
                end
                S_ARM: begin
                    if (fx_rise) begin
                        state    <= S_GATE;
                        fx_cnt   <= '0;
                        base_cnt <= '0;
                        gate_cnt <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state    <= S_DONE;
                        fx_res   <= '0;
                        base_res <= '0;
                        timeout  <= 1'b1;
                        irq      <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_GATE: begin
                    base_cnt <= sat_inc(base_cnt);
                    gate_cnt <= gate_cnt + 1'b1;
                    if (fx_rise) begin
                        fx_cnt <= sat_inc(fx_cnt);
                    end
                    // An edge on the expiry cycle is counted here; the gate then waits for the next one.
                    if (gate_cnt == GATE_LAST) begin
                        state    <= S_CLOSE;
                        wait_cnt <= '0;
                    end
                end
                S_CLOSE: begin
                    base_cnt <= sat_inc(base_cnt);
                    if (fx_rise) begin
                        fx_cnt   <= sat_inc(fx_cnt);
                        fx_res   <= sat_inc(fx_cnt);
                        base_res <= sat_inc(base_cnt);
                        timeout  <= 1'b0;
                        irq      <= 1'b1;
                        busy     <= 1'b0;
                        state    <= S_DONE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state    <= S_DONE;
                        fx_res   <= '0;
                        base_res <= '0;
                        timeout  <= 1'b1;
                        irq      <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (ack) begin
                        irq <= 1'b0;
                        if (auto_mode) begin
                            state    <= S_ARM;
                            busy     <= 1'b1;
                            wait_cnt <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_freq_meas_ctrl.sv
// tb/tb_freq_meas_ctrl.sv - table-driven scoreboard bench for freq_meas_ctrl
module tb_freq_meas_ctrl;
    localparam int GATE = 100;
    localparam int TMO  = 400;
    localparam int NVEC = 8;

    typedef struct {
        int          period;
        bit          rearm;
        logic [31:0] fx_n;
        logic [31:0] base_n;
        logic        to;
    } vec_t;

    typedef struct {
        logic [31:0] fx_n;
        logic [31:0] base_n;
        logic        to;
    } res_t;

    logic       sysclk = 1'b0;
    logic       reset, start, auto_mode, fx, ack;
    logic [2:0] sel;
    logic [7:0] data_out, data_out_s;
    logic       irq, busy, timeout;
    logic       irq_s, busy_s, timeout_s;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   fx_period = 0;
    vec_t vecs[NVEC];
    res_t sb[$];

    always #5 sysclk = ~sysclk;

    freq_meas_ctrl #(.GATE_CYCLES(GATE), .TIMEOUT_CYCLES(TMO), .CNT_W(32)) u_dut (
        .sysclk(sysclk), .reset(reset), .start(start), .auto_mode(auto_mode),
        .fx(fx), .ack(ack), .sel(sel), .data_out(data_out),
        .irq(irq), .busy(busy), .timeout(timeout)
    );

    freq_meas_ctrl #(.GATE_CYCLES(GATE), .TIMEOUT_CYCLES(TMO), .CNT_W(8)) u_sat (
        .sysclk(sysclk), .reset(reset), .start(start), .auto_mode(auto_mode),
        .fx(fx), .ack(ack), .sel(sel), .data_out(data_out_s),
        .irq(irq_s), .busy(busy_s), .timeout(timeout_s)
    );

    // Each rise re-reads fx_period, so a new period takes effect from the next rising edge.
    initial begin
        int p;
        fx = 1'b0;
        forever begin
            if (fx_period == 0) begin
                fx = 1'b0;
                @(negedge sysclk);
            end else begin
                p  = fx_period;
                fx = 1'b1;
                repeat (p / 2) @(negedge sysclk);
                fx = 1'b0;
                repeat (p - p / 2) @(negedge sysclk);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no summary, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        res_t        exp_r, prev_r, tmp;
        logic [31:0] v, sv, eb, seb, prev_eb;
        int          n, held_bad;
        bit          next_rearm;

        reset = 1'b1; start = 1'b0; auto_mode = 1'b0; ack = 1'b0; sel = 3'd0;
        vecs[0] = '{7,   1'b0, 32'd15, 32'd105, 1'b0};
        vecs[1] = '{10,  1'b0, 32'd11, 32'd110, 1'b0};
        vecs[2] = '{0,   1'b0, 32'd0,  32'd0,   1'b1};
        vecs[3] = '{7,   1'b0, 32'd15, 32'd105, 1'b0};
        vecs[4] = '{300, 1'b0, 32'd1,  32'd300, 1'b0};
        vecs[5] = '{7,   1'b0, 32'd15, 32'd105, 1'b0};
        vecs[6] = '{10,  1'b1, 32'd11, 32'd110, 1'b0};
        vecs[7] = '{7,   1'b1, 32'd15, 32'd105, 1'b0};

        repeat (3) tick();
        check("reset_busy", busy, 0);
        check("reset_irq", irq, 0);
        check("reset_timeout", timeout, 0);
        check("reset_data_out", data_out, 0);
        reset = 1'b0;
        prev_r = '{32'd0, 32'd0, 1'b0};
        fx_period = vecs[0].period;
        repeat (20) tick();

        for (int i = 0; i < NVEC; i++) begin
            if (!vecs[i].rearm) begin
                start = 1'b1;
                tick();
                start = 1'b0;
                check("busy_after_start", busy, 1);
            end
            tmp = '{vecs[i].fx_n, vecs[i].base_n, vecs[i].to};
            sb.push_back(tmp);
            sel = 3'b100;
            n = 0;
            held_bad = 0;
            while (!irq && n < 5000) begin
                tick();
                n++;
                if (!irq && data_out !== prev_r.base_n[7:0]) held_bad++;
            end
            check("irq_seen", irq, 1);
            if (irq && sb.size() > 0) begin
                exp_r = sb.pop_front();
                check("timeout_flag", timeout, exp_r.to);
                check("busy_in_done", busy, 0);
                check("irq_sat_inst", irq_s, 1);
                check("dbuf_hold", held_bad, 0);
                if (exp_r.to && !vecs[i].rearm) check("timeout_latency", n, TMO);
                prev_eb = '0;
                for (int b = 0; b < 8; b++) begin
                    sel = 3'(b);
                    #1;
                    if (b > 0) check("sel_registered", data_out, prev_eb);
                    tick();
                    v   = (b < 4) ? exp_r.fx_n : exp_r.base_n;
                    eb  = (v >> (8 * (b % 4))) & 32'hFF;
                    sv  = (v > 32'd255) ? 32'd255 : v;
                    seb = (b % 4 == 0) ? sv : 32'd0;
                    check($sformatf("byte_sel%0d", b), data_out, eb);
                    check($sformatf("sat_byte_sel%0d", b), data_out_s, seb);
                    prev_eb = eb;
                end
                prev_r = exp_r;
            end
            next_rearm = (i < NVEC - 1) ? vecs[i + 1].rearm : 1'b0;
            if (i < NVEC - 1) fx_period = vecs[i + 1].period;
            repeat (20) tick();
            auto_mode = next_rearm;
            ack = 1'b1;
            tick();
            ack = 1'b0;
            check("irq_after_ack", irq, 0);
            check("busy_after_ack", busy, next_rearm);
            if (!next_rearm) repeat (20) tick();
        end

        auto_mode = 1'b0;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("ack_in_idle_busy", busy, 0);
        check("ack_in_idle_irq", irq, 0);

        fx_period = 7;
        start = 1'b1;
        tick();
        start = 1'b0;
        tmp = '{32'd15, 32'd105, 1'b0};
        sb.push_back(tmp);
        n = 0;
        while (!irq && n < 5000) begin
            tick();
            n++;
        end
        check("irq_seen_hand", irq, 1);
        if (sb.size() > 0) begin
            exp_r = sb.pop_front();
            sel = 3'b100;
            tick();
            check("hand_base_b0", data_out, exp_r.base_n[7:0]);
            sel = 3'b000;
            tick();
            check("hand_fx_b0", data_out, exp_r.fx_n[7:0]);
        end

        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_in_done_irq", irq, 1);
        check("start_in_done_busy", busy, 0);

        auto_mode = 1'b1;
        start = 1'b1;
        ack = 1'b1;
        tick();
        start = 1'b0;
        ack = 1'b0;
        check("start_ack_irq", irq, 0);
        check("start_ack_busy", busy, 1);

        repeat (60) tick();
        check("mid_gate_busy", busy, 1);
        reset = 1'b1;
        tick();
        check("midreset_busy", busy, 0);
        check("midreset_irq", irq, 0);
        check("midreset_data_out", data_out, 0);
        check("midreset_timeout", timeout, 0);
        reset = 1'b0;
        auto_mode = 1'b0;
        sel = 3'b100;
        repeat (2) tick();
        check("midreset_results_cleared", data_out, 0);
        check("midreset_stays_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/freq_meas_ctrl.md
Name: freq_meas_ctrl

Overview:
- Sequencer for the equal-precision frequency meter. It runs a programmable gate, aligns the gate's open and close to rising edges of the measured input, and counts both input edges and reference clock cycles over exactly N whole input periods.
- Results are double-buffered. Completion raises an interrupt that the MCU acknowledges; the MCU then reads the counts byte-wise through a registered select port.
- Single `sysclk` domain. `fx` is synchronised internally.

Parameters:
- `GATE_CYCLES`, 50_000_000: minimum gate length in `sysclk` cycles (1 s at 50 MHz).
- `TIMEOUT_CYCLES`, 100_000_000: maximum wait for an `fx` rising edge while arming or closing.
- `CNT_W`, 32: width of `fx_cnt` and `base_cnt`, 8..32, multiple of 8.

Ports:
- `sysclk`  in  1  system clock.
- `reset`  in  1  reset.
- `start`  in  1  one-cycle request to begin a measurement.
- `auto_mode`  in  1  re-arm automatically after `ack`.
- `fx`  in  1  measured signal, asynchronous.
- `ack`  in  1  MCU acknowledge of `irq`.
- `sel`  in  3  readout select: bit 2 = 0 selects `fx_cnt`, 1 selects `base_cnt`; bits [1:0] select the byte index (0 = LSB).
- `data_out`  out  8  selected result byte, registered.
- `irq`  out  1  result ready.
- `busy`  out  1  measurement in progress.
- `timeout`  out  1  last result was aborted for lack of `fx` edges.

Behaviour:
- Clock and reset: one clock, `sysclk`. `reset` is synchronous and active-high.
- On reset:
  - state = IDLE; all counters and latched results = 0.
  - `data_out`, `irq`, `busy`, `timeout` = 0.
- `fx` synchronisation: 2-flop synchroniser plus a previous-value flop. `fx_rise` is a one-cycle pulse. `fx` must be high and low for at least 2 `sysclk` cycles each.
- States:
  - IDLE: `busy` = 0.
    - `start` → ARM.
  - ARM: `busy` = 1; `wait_cnt` counts cycles.
    - `fx_rise` → GATE; `fx_cnt`, `base_cnt`, `gate_cnt` cleared.
    - `wait_cnt` = TIMEOUT_CYCLES-1 → DONE with timeout.
  - GATE: each cycle `base_cnt`+1 and `gate_cnt`+1; each `fx_rise` adds `fx_cnt`+1.
    - `gate_cnt` = GATE_CYCLES-1 → CLOSE. `gate_cnt` is 0 in the first GATE cycle, so this transition happens GATE_CYCLES cycles after the opening edge.
    - An `fx_rise` on that same cycle is counted but does not close the gate.
  - CLOSE: each cycle `base_cnt`+1; `wait_cnt` cleared on entry.
    - `fx_rise`: `fx_cnt`+1 and `base_cnt`+1 are included, and the incremented values are latched into the result registers → DONE.
    - `wait_cnt` = TIMEOUT_CYCLES-1 → DONE with timeout.
  - DONE: `irq` = 1, `busy` = 0.
    - `ack` → ARM if `auto_mode`, else IDLE. `irq` drops the cycle after `ack`.
- Latency: `irq` rises on the cycle after the closing `fx_rise`.
- Result: for `fx` period P cycles and N periods measured, `fx_cnt` = N and `base_cnt` = N·P exactly.
- Timeout: latched `fx_cnt` = 0, `base_cnt` = 0, `timeout` = 1. A normal completion clears `timeout`.
- Saturation: the live counters stop at all-ones and do not wrap.
- Double buffering: latched results and `timeout` change only on entry to DONE or on reset. They remain readable during the next measurement.
- Readout:
  - `data_out` <= selected byte, one cycle after `sel`, in every state.
  - Byte indices at or beyond CNT_W/8 return 0.
- Request rules:
  - `start` outside IDLE is ignored.
  - `ack` outside DONE is ignored.
  - `start` and `ack` together in DONE: `ack` is honoured, `start` is ignored.
- Reset mid-operation: returns to IDLE immediately and discards partial counts and latched results.

Test Plan:
- GATE_CYCLES=100, `fx` period 7, `start` → `irq` one cycle after the 15th rise following the opening edge; `fx_cnt`=15, `base_cnt`=105, `timeout`=0.
- GATE_CYCLES=100, period 10 (a rise coincides with gate expiry) → `fx_cnt`=11, `base_cnt`=110. This checks the simultaneous-edge rule.
- `fx` held low, TIMEOUT_CYCLES=400, `start` → `irq` after 400 ARM cycles; `timeout`=1, both counts 0. Then a normal run clears `timeout`.
- `auto_mode`=1, repeated `ack` → three back-to-back results, each correct. During the run following a completion, `sel`=3'b100 keeps returning the byte latched at that completion until the next DONE.
- `sel` sweep 0..7 after `fx_cnt`=0x12345678, `base_cnt`=0x9ABCDEF0 → bytes 78,56,34,12,F0,DE,BC,9A, each one cycle after `sel` changes.
- `reset` asserted mid-GATE → next cycle state IDLE, `busy`=0, `irq`=0, `data_out`=0. `start` during DONE is ignored.
